// File: rtl/sd_spi_responder.sv
// SD card SPI-mode command responder: receives 48-bit command frames on MOSI,
// tracks the card initialisation flags and answers with R1/R7 on MISO.
module sd_spi_responder #(
    parameter int NCR_CYCLES  = 2,
    parameter int ACMD41_BUSY = 3
) (
    input  logic        SD_clk,
    input  logic        rst_n,
    input  logic        SD_cs,
    input  logic        SD_datain,
    output logic        SD_dataout,
    output logic        cmd_valid,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    output logic        card_ready
);

    typedef enum logic [1:0] {HUNT, RECV, NCR_WAIT, RESP} state_t;

    localparam logic [3:0]  NCR_LAST  = 4'(NCR_CYCLES - 1);
    localparam logic [15:0] BUSY_INIT = 16'(ACMD41_BUSY);

    state_t        state_q, state_d;
    logic [5:0]    bitcnt_q, bitcnt_d;
    logic [3:0]    ncr_q, ncr_d;
    logic [5:0]    rem_q, rem_d;
    logic [46:0]   frame_q, frame_d;
    logic [39:0]   resp_q, resp_d;
    logic          uninit_q, uninit_d;
    logic          idle_q, idle_d;
    logic          app_q, app_d;
    logic [15:0]   busy_q, busy_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [5:0]    cmd_idx_q, cmd_idx_d;
    logic [31:0]   cmd_arg_q, cmd_arg_d;
    logic          ready_q, ready_d;
    logic          dout_q;

    logic [47:0]   frame_full;
    logic [5:0]    idx;
    logic [31:0]   arg;
    logic          crc_ok;
    logic [7:0]    r1_idle;
    logic          accept;
    logic [39:0]   rval;
    logic [5:0]    rlen;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // The bit being sampled this edge completes the frame when bitcnt_q == 47.
    assign frame_full = {frame_q, SD_datain};
    assign idx        = frame_full[45:40];
    assign arg        = frame_full[39:8];
    assign crc_ok     = (crc7(frame_full[47:8]) == frame_full[7:1]);
    assign r1_idle    = {7'b0, idle_q};

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        ncr_d       = ncr_q;
        rem_d       = rem_q;
        frame_d     = frame_q;
        resp_d      = resp_q;
        uninit_d    = uninit_q;
        idle_d      = idle_q;
        app_d       = app_q;
        busy_d      = busy_q;
        cmd_valid_d = 1'b0;
        cmd_idx_d   = cmd_idx_q;
        cmd_arg_d   = cmd_arg_q;
        ready_d     = ready_q;
        accept      = 1'b0;
        rval        = '0;
        rlen        = 6'd8;

        if (SD_cs) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT: begin
                    if (!SD_datain) begin
                        state_d  = RECV;
                        bitcnt_d = 6'd1;
                        frame_d  = '0;
                    end
                end
                RECV: begin
                    frame_d  = frame_full[46:0];
                    bitcnt_d = bitcnt_q + 6'd1;
                    if (bitcnt_q == 6'd47) begin
                        state_d = HUNT;
                        // Until a clean CMD0 arrives the card stays silent.
                        if (frame_full[46] && frame_full[0] &&
                            (!uninit_q || (idx == 6'd0 && crc_ok))) begin
                            accept = 1'b1;
                            case (idx)
                                6'd0: begin
                                    if (crc_ok) begin
                                        idle_d   = 1'b1;
                                        uninit_d = 1'b0;
                                        ready_d  = 1'b0;
                                        app_d    = 1'b0;
                                        busy_d   = BUSY_INIT;
                                        rval     = {8'h01, 32'h0};
                                    end else begin
                                        rval = {r1_idle | 8'h08, 32'h0};
                                    end
                                end
                                6'd8: begin
                                    if (crc_ok) begin
                                        app_d = 1'b0;
                                        rval  = {r1_idle, 20'h0, arg[11:0]};
                                        rlen  = 6'd40;
                                    end else begin
                                        rval = {r1_idle | 8'h08, 32'h0};
                                    end
                                end
                                6'd55: begin
                                    app_d = 1'b1;
                                    rval  = {r1_idle, 32'h0};
                                end
                                6'd41: begin
                                    app_d = 1'b0;
                                    if (!app_q) begin
                                        rval = {r1_idle | 8'h04, 32'h0};
                                    end else if (busy_q != 16'd0) begin
                                        busy_d = busy_q - 16'd1;
                                        rval   = {8'h01, 32'h0};
                                    end else begin
                                        idle_d  = 1'b0;
                                        ready_d = 1'b1;
                                        rval    = {8'h00, 32'h0};
                                    end
                                end
                                default: begin
                                    app_d = 1'b0;
                                    rval  = {r1_idle | 8'h04, 32'h0};
                                end
                            endcase
                        end
                        if (accept) begin
                            state_d     = NCR_WAIT;
                            ncr_d       = '0;
                            resp_d      = rval;
                            rem_d       = rlen;
                            cmd_valid_d = 1'b1;
                            cmd_idx_d   = idx;
                            cmd_arg_d   = arg;
                        end
                    end
                end
                NCR_WAIT: begin
                    if (ncr_q == NCR_LAST) begin
                        state_d = RESP;
                    end else begin
                        ncr_d = ncr_q + 4'd1;
                    end
                end
                RESP: begin
                    if (rem_q == 6'd1) begin
                        state_d = HUNT;
                    end else begin
                        rem_d  = rem_q - 6'd1;
                        resp_d = {resp_q[38:0], 1'b1};
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            bitcnt_q    <= '0;
            ncr_q       <= '0;
            rem_q       <= '0;
            uninit_q    <= 1'b1;
            idle_q      <= 1'b0;
            app_q       <= 1'b0;
            busy_q      <= BUSY_INIT;
            cmd_valid_q <= 1'b0;
            cmd_idx_q   <= '0;
            cmd_arg_q   <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            ncr_q       <= ncr_d;
            rem_q       <= rem_d;
            uninit_q    <= uninit_d;
            idle_q      <= idle_d;
            app_q       <= app_d;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_arg_q   <= cmd_arg_d;
            ready_q     <= ready_d;
        end
    end

    always_ff @(posedge SD_clk) begin
        frame_q <= frame_d;
        resp_q  <= resp_d;
    end

    // MISO launches on the falling edge; CS high blanks it at the very next one.
    always_ff @(negedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 1'b1;
        end else begin
            dout_q <= (state_q == RESP && !SD_cs) ? resp_q[39] : 1'b1;
        end
    end

    assign SD_dataout = dout_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_idx    = cmd_idx_q;
    assign cmd_arg    = cmd_arg_q;
    assign card_ready = ready_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Scoreboard bench for sd_spi_responder: directed SD commands, expected MISO
// responses and cmd_valid events queued by the driver, popped by monitors.
module tb_sd_spi_responder;

    localparam int NCR  = 2;
    localparam int BUSY = 3;

    localparam logic [47:0] CMD0    = 48'h40_0000_0000_95;
    localparam logic [47:0] CMD8    = 48'h48_0000_01AA_87;
    localparam logic [47:0] CMD8BAD = 48'h48_0000_01AA_FF;
    localparam logic [47:0] CMD55   = 48'h77_0000_0000_FF;
    localparam logic [47:0] ACMD41  = 48'h69_4000_0000_FF;
    localparam logic [47:0] CMD17   = 48'h51_0000_0000_FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic        din;
    logic        dout;
    logic        cmd_valid;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        card_ready;

    typedef struct {
        int          len;
        logic [47:0] val;
        int          endc;
    } resp_t;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
    } cmd_t;

    resp_t rq[$];
    cmd_t  cq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 1'b1;
    bit    mon_busy = 1'b0;

    sd_spi_responder #(.NCR_CYCLES(NCR), .ACMD41_BUSY(BUSY)) dut (
        .SD_clk    (clk),
        .rst_n     (rst_n),
        .SD_cs     (cs),
        .SD_datain (din),
        .SD_dataout(dout),
        .cmd_valid (cmd_valid),
        .cmd_idx   (cmd_idx),
        .cmd_arg   (cmd_arg),
        .card_ready(card_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // MISO monitor: a 0 while idle is a response start bit.
    resp_t       r;
    logic [47:0] cap;
    initial forever begin
        @(posedge clk);
        #1;
        if (mon_en && rst_n === 1'b1 && dout === 1'b0) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: start bit at cycle %0d, expected none", cyc);
            end else begin
                r = rq.pop_front();
                mon_busy = 1'b1;
                chk("ncr_gap", 64'(cyc - r.endc), 64'(NCR + 1));
                cap = '0;
                for (int i = 1; i < r.len; i++) begin
                    @(posedge clk);
                    #1;
                    cap = {cap[46:0], dout};
                end
                chk("resp_value", 64'(cap), 64'(r.val));
                if (r.len == 48) chk("r7_cap_19_16", 64'(cap[19:16]), 64'h1);
                mon_busy = 1'b0;
            end
        end
    end

    cmd_t c;
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && cmd_valid === 1'b1) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd_valid: idx %0d, expected no pulse", cmd_idx);
            end else begin
                c = cq.pop_front();
                chk("cmd_idx", 64'(cmd_idx), 64'(c.idx));
                chk("cmd_arg", 64'(cmd_arg), 64'(c.arg));
            end
        end
    end

    task automatic drive_bits(input logic [47:0] f, input int n);
        for (int i = 47; i > 47 - n; i--) begin
            @(negedge clk);
            din = f[i];
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq.size() != 0 || cq.size() != 0 || mon_busy) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("resp_timeout", 64'(n < 300), 64'h1);
        if (n >= 300) begin
            rq.delete();
            cq.delete();
        end
        repeat (NCR + 12) @(posedge clk);
    endtask

    // rlen 0 means the frame must be ignored (no response, no cmd_valid).
    task automatic send(input logic [47:0] f, input int rlen, input logic [47:0] rval);
        drive_bits(f, 47);
        @(negedge clk);
        din = f[0];
        if (rlen != 0) begin
            rq.push_back('{len: rlen, val: rval, endc: cyc + 1});
            cq.push_back('{idx: f[45:40], arg: f[39:8]});
        end
        @(negedge clk);
        din = 1'b1;
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int zeros;
        rst_n = 1'b0;
        cs    = 1'b1;
        din   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 64'(dout), 64'h1);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'h0);
        chk("rst_cmd_idx", 64'(cmd_idx), 64'h0);
        chk("rst_cmd_arg", 64'(cmd_arg), 64'h0);
        chk("rst_card_ready", 64'(card_ready), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);

        send(CMD8, 0, '0);
        chk("uninit_cmd_idx", 64'(cmd_arg), 64'h0);

        send(CMD0, 8, 48'h01);
        chk("cmd0_idx", 64'(cmd_idx), 64'h0);
        send(CMD8, 48, 48'h01_0000_01AA_FF);
        send(CMD8BAD, 8, 48'h09);
        send(ACMD41, 8, 48'h05);
        send(CMD17, 8, 48'h05);

        for (int j = 0; j < 4; j++) begin
            chk("ready_before_acmd41", 64'(card_ready), 64'h0);
            send(CMD55, 8, 48'h01);
            send(ACMD41, 8, (j < 3) ? 48'h01 : 48'h00);
        end
        chk("ready_after_acmd41", 64'(card_ready), 64'h1);

        send(CMD17, 8, 48'h04);
        send(CMD8, 48, 48'h00_0000_01AA_FF);

        // CS raised while the CMD55 response is on the wire.
        mon_en = 1'b0;
        cq.push_back('{idx: 6'd55, arg: 32'h0});
        drive_bits(CMD55, 48);
        @(posedge clk);
        repeat (NCR + 2) @(posedge clk);
        #1;
        chk("abort_resp_started", 64'(dout), 64'h0);
        cs = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_dout", 64'(dout), 64'h1);
        zeros = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (dout !== 1'b1) zeros++;
        end
        cs  = 1'b0;
        din = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (dout !== 1'b1) zeros++;
        end
        chk("abort_quiet", 64'(zeros), 64'h0);
        chk("abort_flags_kept", 64'(card_ready), 64'h1);
        mon_en = 1'b1;
        chk("abort_cmd_seen", 64'(cq.size()), 64'h0);

        // Reset pulsed in the middle of a CMD0 frame.
        drive_bits(CMD0, 20);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", 64'(dout), 64'h1);
        chk("midrst_cmd_valid", 64'(cmd_valid), 64'h0);
        chk("midrst_cmd_idx", 64'(cmd_idx), 64'h0);
        chk("midrst_cmd_arg", 64'(cmd_arg), 64'h0);
        chk("midrst_card_ready", 64'(card_ready), 64'h0);
        @(negedge clk);
        din = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(CMD55, 0, '0);
        send(CMD0, 8, 48'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
